bmp_port_arbiter: RTL
=====================

# bmp_port_arbiter

Sequences and arbitrates all accesses to the single-port byte-wide BMP image buffer in the image-processing testbench. The camera-emulation source requests 24-bit pixel reads at byte indices it computes (header offset already included). The processed-image sink requests 24-bit pixel writes. Each accepted request is converted into a fixed 3-beat byte burst (B, G, R at consecutive addresses). Reads have priority, bounded by a write-starvation guard.

## Interface
- ADDR_W, 32, byte-address width of the buffer
- STARVE_MAX, 4, consecutive read grants allowed while a write is pending before the write is forced; range 1..15
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_req  in  1  read request; held with rd_addr until rd_ack
- rd_addr  in  ADDR_W  byte index of pixel's B byte
- rd_ack  out  1  one-cycle pulse, read request accepted
- rd_valid  out  1  one-cycle pulse, rd_pixel valid
- rd_pixel  out  24  {R,G,B} = {byte+2, byte+1, byte+0}
- wr_req  in  1  write request; held with wr_addr/wr_pixel until wr_ack
- wr_addr  in  ADDR_W  byte index for B byte
- wr_pixel  in  24  {R,G,B}
- wr_ack  out  1  one-cycle pulse, write accepted and data latched
- mem_en  out  1  buffer access strobe
- mem_we  out  1  write enable (valid with mem_en)
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid the cycle after a read beat
- busy  out  1  high while in RD or WR

## Operation
- FSM states: IDLE, RD, WR; beat counter 0..2.
- IDLE: sample requests each cycle. If rd_req and not forced write: go to RD. If wr_req and (no rd_req or starve count == STARVE_MAX): go to WR. Otherwise stay in IDLE.
- On grant, latch the address (and wr_pixel for a write).
- RD/WR: issue beat k at mem_addr = base + k, with k = 0,1,2. Addition wraps modulo 2^ADDR_W. After beat 2, return to IDLE. Chaining is not allowed.
- Write beats: mem_we = 1. mem_wdata = pixel[7:0], then [15:8], then [23:16].
- Read beats: mem_we = 0. Capture mem_rdata the cycle after each beat into byte lanes 0, 1, 2.
- Starve counter:
  - Increments on each read grant taken while wr_req = 1, saturating at STARVE_MAX.
  - Clears on write grant, or in any cycle where wr_req = 0.
- Requests arriving during a burst wait. A request is never dropped while held.
- Reset mid-burst: the burst is abandoned, no rd_valid is issued, and all latched state clears.

## Timing
- Reset values: rd_ack, rd_valid, wr_ack, mem_en, mem_we, busy all 0; rd_pixel, mem_addr, mem_wdata all 0; state IDLE; starve count 0.
- Request sampled high in IDLE at cycle T:
  - Beats occupy T+1, T+2, T+3.
  - rd_ack / wr_ack pulse in T+1.
  - busy is high T+1..T+3.
- Read: bytes arrive T+2..T+4. rd_valid and rd_pixel are registered, valid in T+5. rd_pixel holds until the next rd_valid.
- Earliest next grant sample is T+4, giving a 4-cycle burst period.
- The requester drops req the cycle after ack. If req is still high at the next IDLE sample, it is treated as a new request.
- mem_en is high only in beat cycles. mem_addr and mem_wdata hold their last values otherwise.

## Structure
- Package bmp_arb_pkg holds: the state enum (IDLE, RD, WR), BEATS = 3, BEAT_W = 2, and the byte-lane index constants for B/G/R.
- Single module; no sub-module needed. Starve counter and pixel packer stay inline.

## Test plan
- Single read, rd_addr = 54, buffer bytes 54..56 = 0x11, 0x22, 0x33 -> mem_addr 54, 55, 56 in T+1..T+3; rd_valid in T+5 with rd_pixel = 0x332211.
- Single write, wr_addr = 2454, wr_pixel = 0xA1B2C3 -> mem_we beats write 0xC3, 0xB2, 0xA1 to 2454..2456; wr_ack in T+1; read back gives 0xA1B2C3.
- rd_req and wr_req held continuously, STARVE_MAX = 4 -> grant order R, R, R, R, W, R, R, R, R, W; grants exactly 4 cycles apart.
- rd_addr = 0xFFFF_FFFE -> beat addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- rst_n asserted in T+2 of a read burst -> all outputs 0 immediately, no rd_valid afterwards; a new read after release completes normally.
- wr_req drops after 2 read grants, then rises again -> starve count restarts from 0, so 4 more reads precede the write.

Source files
------------

// File: rtl/bmp_arb_pkg.sv
// Shared types and constants for the BMP image-buffer port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, RD, WR)
//   BEATS/BEAT_W: fixed 3-beat byte burst per pixel and its counter width
//   LANE_*      : byte-lane index of B/G/R inside a 24-bit {R,G,B} pixel
package bmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_e;

    localparam int unsigned BEATS   = 3;
    localparam int unsigned BEAT_W  = 2;
    localparam int unsigned PIXEL_W = 24;

    localparam logic [BEAT_W-1:0] LANE_B = 2'd0;
    localparam logic [BEAT_W-1:0] LANE_G = 2'd1;
    localparam logic [BEAT_W-1:0] LANE_R = 2'd2;

    // Byte of a pixel that travels on beat 'lane'.
    function automatic logic [7:0] pixel_byte(input logic [PIXEL_W-1:0] pix,
                                              input logic [BEAT_W-1:0]  lane);
        case (lane)
            LANE_B:  return pix[7:0];
            LANE_G:  return pix[15:8];
            default: return pix[23:16];
        endcase
    endfunction

endpackage

// File: rtl/bmp_port_arbiter_if.sv
// Bus bundle between the pixel requesters / image buffer and the arbiter.
//   slave  : arbiter side (takes requests and read data, drives acks and the buffer port)
//   master : environment side (requesters plus the byte-wide buffer)
interface bmp_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    import bmp_arb_pkg::*;

    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ack;
    logic               rd_valid;
    logic [PIXEL_W-1:0] rd_pixel;
    logic               wr_req;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIXEL_W-1:0] wr_pixel;
    logic               wr_ack;
    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_wdata;
    logic [7:0]         mem_rdata;
    logic               busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_pixel, mem_rdata,
        output rd_ack, rd_valid, rd_pixel, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_pixel, mem_rdata,
        input  rd_ack, rd_valid, rd_pixel, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/bmp_port_arbiter.sv
// Arbitrates 24-bit pixel reads and writes onto a single-port byte-wide image buffer.
// Each grant becomes a 3-beat burst (B, G, R at base, base+1, base+2). Reads win
// unless a pending write has already been passed over STARVE_MAX times in a row.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/ack handshakes, returned pixel and the buffer port (slave side)
module bmp_port_arbiter
    import bmp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    bmp_port_arbiter_if.slave bus
);

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

    arb_state_e         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic [3:0]         starve_q, starve_d;
    logic               rd_ack_q, rd_ack_d;
    logic               wr_ack_q, wr_ack_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    // Read-data capture runs one cycle behind the beats it belongs to.
    logic               cap_en_q, cap_en_d;
    logic [BEAT_W-1:0]  cap_lane_q, cap_lane_d;
    logic [15:0]        cap_buf_q, cap_buf_d;
    logic               rd_valid_q, rd_valid_d;
    logic [PIXEL_W-1:0] rd_pixel_q, rd_pixel_d;
    logic               force_wr;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        pix_d       = pix_q;
        starve_d    = starve_q;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        force_wr    = bus.wr_req && (starve_q == STARVE_LIM);

        if (!bus.wr_req) begin
            starve_d = 4'd0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.rd_req && !force_wr) begin
                    state_d    = RD;
                    base_d     = bus.rd_addr;
                    beat_d     = '0;
                    rd_ack_d   = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.rd_addr;
                    if (bus.wr_req && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.wr_req) begin
                    state_d     = WR;
                    base_d      = bus.wr_addr;
                    pix_d       = bus.wr_pixel;
                    beat_d      = '0;
                    wr_ack_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.wr_addr;
                    mem_wdata_d = pixel_byte(bus.wr_pixel, LANE_B);
                    starve_d    = 4'd0;
                end
            end
            RD, WR: begin
                // beat_q is the beat currently on the bus; no chaining after the last one.
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d     = beat_q + 1'b1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = (state_q == WR);
                    mem_addr_d = base_q + ADDR_W'(beat_d);
                    if (state_q == WR) begin
                        mem_wdata_d = pixel_byte(pix_q, beat_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_en_d   = mem_en_q && !mem_we_q;
        cap_lane_d = beat_q;
        cap_buf_d  = cap_buf_q;
        rd_valid_d = 1'b0;
        rd_pixel_d = rd_pixel_q;
        if (cap_en_q) begin
            unique case (cap_lane_q)
                LANE_B: cap_buf_d[7:0]  = bus.mem_rdata;
                LANE_G: cap_buf_d[15:8] = bus.mem_rdata;
                LANE_R: begin
                    rd_valid_d = 1'b1;
                    rd_pixel_d = {bus.mem_rdata, cap_buf_q};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            pix_q       <= '0;
            starve_q    <= '0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cap_en_q    <= 1'b0;
            cap_lane_q  <= '0;
            cap_buf_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_pixel_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            pix_q       <= pix_d;
            starve_q    <= starve_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cap_en_q    <= cap_en_d;
            cap_lane_q  <= cap_lane_d;
            cap_buf_q   <= cap_buf_d;
            rd_valid_q  <= rd_valid_d;
            rd_pixel_q  <= rd_pixel_d;
        end
    end

    assign bus.rd_ack    = rd_ack_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_pixel  = rd_pixel_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
